// File: rtl/mvb_items_gather_pkg.sv
// ---------------------------------------------------------------------------
// mvb_items_gather_pkg
//  Shared types and sizing helpers for the MVB item gatherer.
//  - gather_state_t : accumulate-mode FSM states (IDLE, COLLECT)
//  - addr_w()       : FIFO pointer width for a given depth
//  - cnt_w()        : timeout counter width for a given TIMEOUT
// ---------------------------------------------------------------------------
package mvb_items_gather_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } gather_state_t;

    // Pointer width; clamped to 1 so a degenerate depth still elaborates.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mvb_gather_chan_fifo.sv
// ---------------------------------------------------------------------------
// mvb_gather_chan_fifo
//  Per-channel register-array FIFO used by mvb_items_gather.
//  Ports:
//   clk, reset  : clock, synchronous active-high reset
//   wr_en, din  : push (never asserted while full)
//   rd_en, dout : pop; dout shows the current head (valid while !empty)
//   empty       : FIFO holds no item
//   empty_next  : FIFO will hold no item after this edge
//   full        : registered full flag
//  Simultaneous push and pop is legal at any fill level, including 1 item.
// ---------------------------------------------------------------------------
module mvb_gather_chan_fifo
    import mvb_items_gather_pkg::*;
#(
    parameter int ITEM_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ITEM_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [ITEM_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  empty_next,
    output logic                  full
);
    localparam int ADDR_W = addr_w(FIFO_DEPTH);

    logic [ITEM_WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_reg;
    logic [ADDR_W-1:0]     rd_ptr_reg;
    logic [ADDR_W:0]       count_reg;
    logic [ADDR_W:0]       count_next;
    logic                  full_reg;

    assign count_next = count_reg + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);

    // Storage has no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == (ADDR_W+1)'(FIFO_DEPTH));
        end
    end

    assign dout       = mem_reg[rd_ptr_reg];
    assign empty      = (count_reg == '0);
    assign empty_next = (count_next == '0);
    assign full       = full_reg;

endmodule

// File: rtl/mvb_items_gather.sv
// ---------------------------------------------------------------------------
// mvb_items_gather
//  Gathers ITEMS single-item MVB streams into one ITEMS-wide MVB word.
//  Channel i always lands in output slot i; each channel has its own FIFO.
//  Ports:
//   clk, reset  : clock, synchronous active-high reset
//   rx_data     : channel i data at [i*ITEM_WIDTH +: ITEM_WIDTH]
//   rx_vld      : per-channel item valid
//   rx_src_rdy  : per-channel source ready
//   rx_dst_rdy  : per-channel destination ready (registered !full)
//   tx_data     : gathered word, slot i from channel i
//   tx_vld      : per-slot valid
//   tx_src_rdy  : word valid
//   tx_dst_rdy  : downstream ready
//  Build option MVB_GATHER_TIMEOUT_EN:
//   undefined : greedy, emit whenever any FIFO holds an item
//   defined   : accumulate, emit when every FIFO holds an item, when the
//               wait counter reaches TIMEOUT-1, or when any FIFO is full
// ---------------------------------------------------------------------------
module mvb_items_gather
    import mvb_items_gather_pkg::*;
#(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ITEMS*ITEM_WIDTH-1:0] rx_data,
    input  logic [ITEMS-1:0]            rx_vld,
    input  logic [ITEMS-1:0]            rx_src_rdy,
    output logic [ITEMS-1:0]            rx_dst_rdy,
    output logic [ITEMS*ITEM_WIDTH-1:0] tx_data,
    output logic [ITEMS-1:0]            tx_vld,
    output logic                        tx_src_rdy,
    input  logic                        tx_dst_rdy
);
    logic [ITEMS-1:0]            wr_en;
    logic [ITEMS-1:0]            rd_en;
    logic [ITEMS-1:0]            empty;
    logic [ITEMS-1:0]            empty_next;
    logic [ITEMS-1:0]            full;
    logic [ITEMS*ITEM_WIDTH-1:0] fifo_dout;

    logic                        any_ne;
    logic                        emit;
    logic                        load;

    logic                        tx_src_rdy_reg;
    logic [ITEMS-1:0]            tx_vld_reg;
    logic [ITEMS*ITEM_WIDTH-1:0] tx_data_reg;

    assign any_ne = ~&empty;
    // The output register takes a new word when it is free or being drained.
    assign load   = (~tx_src_rdy_reg | tx_dst_rdy) & emit;

    for (genvar gi = 0; gi < ITEMS; gi++) begin : g_chan
        // A beat with rx_vld low is still consumed, it just writes nothing.
        assign wr_en[gi] = rx_src_rdy[gi] & rx_vld[gi] & ~full[gi];
        assign rd_en[gi] = load & ~empty[gi];

        mvb_gather_chan_fifo #(
            .ITEM_WIDTH (ITEM_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en[gi]),
            .din        (rx_data[gi*ITEM_WIDTH +: ITEM_WIDTH]),
            .rd_en      (rd_en[gi]),
            .dout       (fifo_dout[gi*ITEM_WIDTH +: ITEM_WIDTH]),
            .empty      (empty[gi]),
            .empty_next (empty_next[gi]),
            .full       (full[gi])
        );
    end

    assign rx_dst_rdy = ~full;

`ifdef MVB_GATHER_TIMEOUT_EN
    localparam int               CNT_W    = cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    gather_state_t    state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             all_ne;
    logic             any_full;
    logic             any_ne_next;
    logic             timed_out;

    assign all_ne      = &(~empty);
    assign any_full    = |full;
    assign any_ne_next = ~&empty_next;
    assign timed_out   = (state_reg == COLLECT) && (cnt_reg == CNT_LAST);
    // Full FIFOs force an emit so a stalled channel can never deadlock the rest.
    assign emit        = any_ne & (all_ne | timed_out | any_full);

    // COLLECT is entered on the same edge the first item is written, so the
    // counter measures how long the oldest buffered item has been waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_ne_next) begin
                        state_reg <= COLLECT;
                        cnt_reg   <= '0;
                    end
                end
                COLLECT: begin
                    if (load) begin
                        if (!any_ne_next) begin
                            state_reg <= IDLE;
                        end
                        cnt_reg <= '0;
                    end else if (cnt_reg != CNT_LAST) begin
                        // Saturates at TIMEOUT-1 while a TX stall blocks the emit.
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end
`else
    logic unused_cfg;

    assign emit       = any_ne;
    assign unused_cfg = ^{empty_next, TIMEOUT[0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_src_rdy_reg <= 1'b0;
            tx_vld_reg     <= '0;
            tx_data_reg    <= '0;
        end else if (load) begin
            tx_src_rdy_reg <= 1'b1;
            tx_vld_reg     <= ~empty;
            tx_data_reg    <= fifo_dout;
        end else if (tx_dst_rdy) begin
            tx_src_rdy_reg <= 1'b0;
            tx_vld_reg     <= '0;
        end
    end

    assign tx_src_rdy = tx_src_rdy_reg;
    assign tx_vld     = tx_vld_reg;
    assign tx_data    = tx_data_reg;

endmodule

// File: tb/tb_mvb_items_gather.sv
// ---------------------------------------------------------------------------
// tb_mvb_items_gather
//  Self-checking bench for mvb_items_gather (ITEMS=4, ITEM_WIDTH=8,
//  FIFO_DEPTH=4, TIMEOUT=16). Works in both builds of MVB_GATHER_TIMEOUT_EN.
//  A per-channel queue scoreboard follows every RX and TX handshake; directed
//  scenarios add timing and grouping checks; a random phase closes the run.
// ---------------------------------------------------------------------------
module tb_mvb_items_gather;
    localparam int ITEMS      = 4;
    localparam int IW         = 8;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ITEMS*IW-1:0]  rx_data;
    logic [ITEMS-1:0]     rx_vld;
    logic [ITEMS-1:0]     rx_src_rdy;
    logic [ITEMS-1:0]     rx_dst_rdy;
    logic [ITEMS*IW-1:0]  tx_data;
    logic [ITEMS-1:0]     tx_vld;
    logic                 tx_src_rdy;
    logic                 tx_dst_rdy;

    mvb_items_gather #(
        .ITEMS      (ITEMS),
        .ITEM_WIDTH (IW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_src_rdy (rx_src_rdy),
        .rx_dst_rdy (rx_dst_rdy),
        .tx_data    (tx_data),
        .tx_vld     (tx_vld),
        .tx_src_rdy (tx_src_rdy),
        .tx_dst_rdy (tx_dst_rdy)
    );

    always #5 clk = ~clk;

    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  tx_words = 0;
    int                  popped [ITEMS];
    logic [IW-1:0]       sb_q [ITEMS][$];
    bit                  hold_pending = 0;
    logic [ITEMS-1:0]    held_vld;
    logic [ITEMS*IW-1:0] held_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe handshakes for the cycle about to close, then advance one clock.
    task automatic step();
        logic [IW-1:0] exp_item;
        if (reset) begin
            for (int i = 0; i < ITEMS; i++) sb_q[i].delete();
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("tx_hold_vld", tx_vld, held_vld);
                check("tx_hold_data", tx_data, held_data);
            end
            for (int i = 0; i < ITEMS; i++) begin
                if (rx_src_rdy[i] && rx_dst_rdy[i] && rx_vld[i])
                    sb_q[i].push_back(rx_data[i*IW +: IW]);
            end
            if (tx_src_rdy && tx_dst_rdy) begin
                tx_words++;
                $display("tx word %0d: vld=%b data=%h", tx_words, tx_vld, tx_data);
                for (int i = 0; i < ITEMS; i++) begin
                    if (tx_vld[i]) begin
                        if (sb_q[i].size() == 0) begin
                            check("sb_extra_item", 1, 0);
                        end else begin
                            exp_item = sb_q[i].pop_front();
                            check("sb_slot_item", tx_data[i*IW +: IW], exp_item);
                            popped[i]++;
                        end
                    end
                end
            end
            hold_pending = tx_src_rdy && !tx_dst_rdy;
            held_vld     = tx_vld;
            held_data    = tx_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_src_rdy = '0;
        rx_vld     = '0;
        rx_data    = '0;
    endtask

    task automatic send(input int ch, input logic [IW-1:0] d);
        rx_src_rdy[ch]        = 1'b1;
        rx_vld[ch]            = 1'b1;
        rx_data[ch*IW +: IW]  = d;
    endtask

    task automatic wait_word(output int n);
        n = 0;
        while (!tx_src_rdy && n < 200) begin
            step();
            n++;
        end
        if (!tx_src_rdy) check("wait_word_timeout", 0, 1);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        int left;
        left = 0;
        for (int i = 0; i < ITEMS; i++) left += sb_q[i].size();
        while ((left != 0 || tx_src_rdy) && n < max_cycles) begin
            step();
            n++;
            left = 0;
            for (int i = 0; i < ITEMS; i++) left += sb_q[i].size();
        end
        check("drain_left", left, 0);
    endtask

    initial begin
        int n;
        int w;
        int idx;
        int cyc;
        bit acc;

        for (int i = 0; i < ITEMS; i++) popped[i] = 0;
        reset      = 1'b1;
        tx_dst_rdy = 1'b1;
        idle_inputs();
        repeat (3) step();
        check("rst_tx_src_rdy", tx_src_rdy, 0);
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_dst_rdy", rx_dst_rdy, 4'b1111);
        reset = 1'b0;
        step();

        // 1: single item on channel 2
        send(2, 8'hA5);
        step();
        idle_inputs();
        wait_word(n);
`ifdef MVB_GATHER_TIMEOUT_EN
        check("t1_latency_window", (n >= TIMEOUT - 1 && n <= TIMEOUT + 1), 1);
`else
        check("t1_latency", n, 1);
`endif
        check("t1_vld", tx_vld, 4'b0100);
        check("t1_slot2", tx_data[2*IW +: IW], 8'hA5);
        step();
        check("t1_one_cycle", tx_src_rdy, 0);

        // 2: all channels in the same cycle form one full word
        for (int i = 0; i < ITEMS; i++) send(i, 8'(8'h10 + i));
        step();
        idle_inputs();
        wait_word(n);
        check("t2_latency", n, 1);
        check("t2_vld", tx_vld, 4'b1111);
        check("t2_data", tx_data, 32'h13121110);
        w = tx_words;
        repeat (5) step();
        check("t2_single_word", tx_words - w, 1);

        // 3: backpressure on channel 0
        tx_dst_rdy = 1'b0;
        idx = 1;
        cyc = 0;
        while (idx <= 5 && cyc < 40) begin
            send(0, 8'(idx));
            acc = rx_dst_rdy[0];
            step();
            if (acc) idx++;
            cyc++;
        end
        check("t3_accepted", idx - 1, 5);
        send(0, 8'h06);
        for (int k = 0; k < 3; k++) begin
            check("t3_full_blocks", rx_dst_rdy[0], 0);
            step();
        end
        idle_inputs();
        check("t3_tx_held", tx_src_rdy, 1);
        check("t3_tx_head", tx_data[IW-1:0], 8'h01);
        check("t3_other_chan_rdy", rx_dst_rdy[3:1], 3'b111);
        w = popped[0];
        tx_dst_rdy = 1'b1;
        drain(300);
        check("t3_drained", popped[0] - w, 5);

        // 4: source-ready beats without valid are dropped
        w = tx_words;
        rx_src_rdy[1] = 1'b1;
        rx_vld[1]     = 1'b0;
        rx_data[IW +: IW] = 8'hEE;
        repeat (3) step();
        idle_inputs();
        repeat (20) step();
        check("t4_no_tx", tx_words - w, 0);
        check("t4_rx_rdy", rx_dst_rdy[1], 1);
        send(1, 8'h77);
        step();
        idle_inputs();
        wait_word(n);
        check("t4_vld", tx_vld, 4'b0010);
        check("t4_slot1", tx_data[IW +: IW], 8'h77);
        drain(100);

`ifdef MVB_GATHER_TIMEOUT_EN
        // 5: partial word waits for the timeout and gathers a late channel
        w = tx_words;
        send(0, 8'h22);
        step();
        idle_inputs();
        repeat (4) step();
        send(3, 8'h33);
        step();
        idle_inputs();
        wait_word(n);
        check("t5_latency_window", (n + 5 >= TIMEOUT - 1 && n + 5 <= TIMEOUT + 1), 1);
        check("t5_vld", tx_vld, 4'b1001);
        check("t5_slot0", tx_data[IW-1:0], 8'h22);
        check("t5_slot3", tx_data[3*IW +: IW], 8'h33);
        repeat (20) step();
        check("t5_single_word", tx_words - w, 1);
`endif

        // 6: reset with items buffered and TX stalled
        tx_dst_rdy = 1'b0;
        send(0, 8'h61);
        step();
        idle_inputs();
        send(1, 8'h62);
        send(2, 8'h63);
        step();
        idle_inputs();
        send(3, 8'h64);
        step();
        idle_inputs();
        check("t6_stalled", tx_src_rdy, 1);
        reset = 1'b1;
        step();
        check("t6_tx_src_rdy", tx_src_rdy, 0);
        check("t6_tx_vld", tx_vld, 0);
        check("t6_rx_dst_rdy", rx_dst_rdy, 4'b1111);
        reset      = 1'b0;
        tx_dst_rdy = 1'b1;
        w = tx_words;
        repeat (40) step();
        check("t6_no_stale", tx_words - w, 0);

        // Random traffic against the per-channel scoreboard
        for (int c = 0; c < 2000; c++) begin
            rx_src_rdy = 4'($urandom);
            rx_vld     = 4'($urandom | $urandom);
            rx_data    = $urandom;
            tx_dst_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();
        tx_dst_rdy = 1'b1;
        drain(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
